outbuf_vc: RTL

- Per-virtual-channel output buffer directly downstream of the router's 2:1 mux.
- Captures the mux output flit (odata/ovalid/ovch) into one FIFO per VC.
- Arbitrates among VCs round-robin and drives the registered output link using credit-based flow control toward the next router.
- Returns per-VC full flags upstream so the mux's sources can stall.

---
 rtl/outbuf_vc_if.sv | 27 ++
 rtl/outbuf_vc.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/outbuf_vc_if.sv
// Flit link bundle around the per-VC output buffer: mux-side write port, full flags,
// registered output link and returning credits.
interface outbuf_vc_if #(
  parameter int DATA_W = 66,
  parameter int VCH_W  = 1
);
  localparam int NVC = 2**VCH_W;

  logic [DATA_W-1:0] idata;
  logic              ivalid;
  logic [VCH_W-1:0]  ivch;
  logic [NVC-1:0]    ifull;
  logic [DATA_W-1:0] odata;
  logic              ovalid;
  logic [VCH_W-1:0]  ovch;
  logic [NVC-1:0]    icredit;

  modport master (
    output idata, ivalid, ivch, icredit,
    input  ifull, odata, ovalid, ovch
  );

  modport slave (
    input  idata, ivalid, ivch, icredit,
    output ifull, odata, ovalid, ovch
  );
endinterface

// File: rtl/outbuf_vc.sv
// Per-VC output buffer: one FIFO per VC, round-robin arbiter, credit-gated registered link.
// Defining OUTBUF_PKT_LOCK_EN adds a wormhole lock (HEAD locks the arbiter to its VC until TAIL).
module outbuf_vc #(
  parameter int DATA_W   = 66,
  parameter int VCH_W    = 1,
  parameter int DEPTH    = 4,
  parameter int CRED_MAX = 4
) (
  input  logic       clk,
  input  logic       rst_,
  outbuf_vc_if.slave link,
  output logic       oerr
);
  localparam int NVC    = 2**VCH_W;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int CRED_W = $clog2(CRED_MAX + 1);

  logic [DATA_W-1:0] mem    [NVC][DEPTH];
  logic [PTR_W-1:0]  wr_ptr [NVC];
  logic [PTR_W-1:0]  rd_ptr [NVC];
  logic [CNT_W-1:0]  count  [NVC];
  logic [CRED_W-1:0] credit [NVC];
  logic [VCH_W-1:0]  rr_ptr;

  logic [NVC-1:0]    full, elig, wr_sel, rd_sel, cr_inc, cr_err;
  logic              drop, grant;
  logic [VCH_W-1:0]  win, cand;
  logic [DATA_W-1:0] head_flit;

`ifdef OUTBUF_PKT_LOCK_EN
  // state    | meaning
  // UNLOCKED | per-flit round-robin among eligible VCs
  // LOCKED   | a packet is in flight on lock_vc; only lock_vc may be granted
  typedef enum logic {UNLOCKED, LOCKED} lock_t;
  localparam logic [1:0] TYPE_HEAD = 2'b01;
  localparam logic [1:0] TYPE_TAIL = 2'b11;

  lock_t            lock_state, lock_next;
  logic [VCH_W-1:0] lock_vc, lock_vc_next;
`endif

  always_comb begin
    full = '0;
    elig = '0;
    for (int v = 0; v < NVC; v++) begin
      full[v] = (count[v] == CNT_W'(DEPTH));
      elig[v] = (count[v] != '0) && (credit[v] != '0);
    end
  end

  assign link.ifull = full;
  assign drop       = link.ivalid && full[link.ivch];

  always_comb begin
    grant = 1'b0;
    win   = '0;
    cand  = '0;
`ifdef OUTBUF_PKT_LOCK_EN
    if (lock_state == LOCKED) begin
      grant = elig[lock_vc];
      win   = lock_vc;
    end else begin
`endif
      for (int i = 0; i < NVC; i++) begin
        cand = rr_ptr + VCH_W'(i);
        if (!grant && elig[cand]) begin
          grant = 1'b1;
          win   = cand;
        end
      end
`ifdef OUTBUF_PKT_LOCK_EN
    end
`endif
    head_flit = mem[win][rd_ptr[win]];
  end

`ifdef OUTBUF_PKT_LOCK_EN
  always_comb begin
    lock_next    = lock_state;
    lock_vc_next = lock_vc;
    if (grant) begin
      if (head_flit[DATA_W-1 -: 2] == TYPE_HEAD) begin
        lock_next    = LOCKED;
        lock_vc_next = win;
      end else if (head_flit[DATA_W-1 -: 2] == TYPE_TAIL) begin
        lock_next = UNLOCKED;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      lock_state <= UNLOCKED;
      lock_vc    <= '0;
    end else begin
      lock_state <= lock_next;
      lock_vc    <= lock_vc_next;
    end
  end
`endif

  // A same-cycle send absorbs the returning credit; a credit at CRED_MAX is an error.
  always_comb begin
    wr_sel = '0;
    rd_sel = '0;
    cr_inc = '0;
    cr_err = '0;
    for (int v = 0; v < NVC; v++) begin
      wr_sel[v] = link.ivalid && (link.ivch == VCH_W'(v)) && !full[v];
      rd_sel[v] = grant && (win == VCH_W'(v));
      cr_inc[v] = link.icredit[v] && !rd_sel[v] && (credit[v] != CRED_W'(CRED_MAX));
      cr_err[v] = link.icredit[v] && !rd_sel[v] && (credit[v] == CRED_W'(CRED_MAX));
    end
  end

  always_ff @(posedge clk) begin
    for (int v = 0; v < NVC; v++) begin
      if (wr_sel[v]) mem[v][wr_ptr[v]] <= link.idata;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      for (int v = 0; v < NVC; v++) begin
        wr_ptr[v] <= '0;
        rd_ptr[v] <= '0;
        count[v]  <= '0;
        credit[v] <= CRED_W'(CRED_MAX);
      end
      rr_ptr      <= '0;
      link.odata  <= '0;
      link.ovalid <= 1'b0;
      link.ovch   <= '0;
      oerr        <= 1'b0;
    end else begin
      for (int v = 0; v < NVC; v++) begin
        wr_ptr[v] <= wr_ptr[v] + PTR_W'(wr_sel[v]);
        rd_ptr[v] <= rd_ptr[v] + PTR_W'(rd_sel[v]);
        count[v]  <= count[v] + CNT_W'(wr_sel[v]) - CNT_W'(rd_sel[v]);
        if (rd_sel[v] && !link.icredit[v]) credit[v] <= credit[v] - CRED_W'(1);
        else if (cr_inc[v])                credit[v] <= credit[v] + CRED_W'(1);
      end
      link.ovalid <= grant;
      if (grant) begin
        link.odata <= head_flit;
        link.ovch  <= win;
        rr_ptr     <= win + VCH_W'(1);
      end
      oerr <= oerr | drop | (|cr_err);
    end
  end
endmodule
